// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Sums N_TERMS unsigned 8-bit products from the 4x4 array multiplier into a
// 12-bit result. Products arrive through a valid/ready input port. Each
// completed sum is held on a valid/ready output port until the consumer takes
// it.
//
// Handshake semantics (both ports): a transfer happens in exactly the cycles
// where valid and ready are both 1 at the rising clock edge. The producer
// holds its data while valid=1 and ready=0. in_ready depends only on the
// state and on clear, never on in_valid. out_valid is a registered output.
//
// Parameters
//   N_TERMS    number of products summed per result, 1..16
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset; overrides every other input
//   prod_in    unsigned product (8 bits)
//   in_valid   prod_in is valid this cycle
//   in_ready   the block accepts prod_in this cycle
//   clear      aborts the current accumulation or discards a pending result
//   out_sum    completed sum (12 bits); keeps its value after out_valid falls
//   out_valid  out_sum holds a completed result
//   out_ready  the consumer takes out_sum this cycle
//   term_cnt   number of products accepted into the current accumulation
//   fsm_state  debug view of the state register (0 = ACC, 1 = HOLD)
// -----------------------------------------------------------------------------
module product_accumulator #(
  parameter int N_TERMS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  prod_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        clear,
  output logic [11:0] out_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  term_cnt,
  output logic        fsm_state
);

  typedef enum logic {
    ACC  = 1'b0,  // collecting products
    HOLD = 1'b1   // result pending on the output port
  } state_t;

  // Index of the final term of a run. term_cnt holds this value while the
  // last product is being offered.
  localparam logic [4:0] LAST_IDX = 5'(N_TERMS - 1);

  state_t      state_q, state_d;
  logic [11:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [11:0] sum_q, sum_d;

  logic        accept;
  logic        last_term;
  logic [11:0] acc_plus;

  // Sixteen products of at most 225 sum to 3600, which fits in 12 bits, so
  // the adder never wraps and needs no saturation.
  assign acc_plus  = acc_q + {4'b0000, prod_in};
  assign accept    = in_valid && in_ready;
  assign last_term = (cnt_q == LAST_IDX);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    in_ready = 1'b0;

    unique case (state_q)
      ACC: begin
        // clear blocks acceptance, so a product offered with clear is dropped.
        in_ready = !clear;
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (accept) begin
          if (last_term) begin
            // The final product goes straight into the result. The
            // accumulator is emptied for the next run.
            sum_d   = acc_plus;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            acc_d = acc_plus;
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      HOLD: begin
        // No bypass: the earliest new product arrives the cycle after the
        // handshake. clear discards the result ahead of out_ready. sum_q is
        // left as it is in both cases.
        in_ready = 1'b0;
        if (clear || out_ready) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ACC;
      end
    endcase
  end

  assign out_sum   = sum_q;
  assign out_valid = (state_q == HOLD);
  assign term_cnt  = cnt_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//
// Three instances share one stimulus stream: N_TERMS = 4, 16 and 1. Each test
// checks only the instance it targets. The N_TERMS=4 scenarios come from a
// per-cycle vector table. The 16-term and 1-term runs are written out by hand.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] prod_in;
  logic       in_valid;
  logic       clear;
  logic       out_ready;

  logic        rdy4, vld4, st4;
  logic [11:0] sum4;
  logic [4:0]  cnt4;
  logic        rdy16, vld16, st16;
  logic [11:0] sum16;
  logic [4:0]  cnt16;
  logic        rdy1, vld1, st1;
  logic [11:0] sum1;
  logic [4:0]  cnt1;

  product_accumulator #(.N_TERMS(4)) u_dut4 (
    .clk(clk), .rst(rst), .prod_in(prod_in), .in_valid(in_valid),
    .in_ready(rdy4), .clear(clear), .out_sum(sum4), .out_valid(vld4),
    .out_ready(out_ready), .term_cnt(cnt4), .fsm_state(st4)
  );

  product_accumulator #(.N_TERMS(16)) u_dut16 (
    .clk(clk), .rst(rst), .prod_in(prod_in), .in_valid(in_valid),
    .in_ready(rdy16), .clear(clear), .out_sum(sum16), .out_valid(vld16),
    .out_ready(out_ready), .term_cnt(cnt16), .fsm_state(st16)
  );

  product_accumulator #(.N_TERMS(1)) u_dut1 (
    .clk(clk), .rst(rst), .prod_in(prod_in), .in_valid(in_valid),
    .in_ready(rdy1), .clear(clear), .out_sum(sum1), .out_valid(vld1),
    .out_ready(out_ready), .term_cnt(cnt1), .fsm_state(st1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];  // expected out_sum of each completed result, in order

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table for the N_TERMS=4 instance. One record is one clock cycle.
  // exp_rdy is checked before the edge. The other expected fields are checked
  // just after it.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rst;
    logic        clr;
    logic        iv;
    logic [7:0]  prod;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_vld;
    logic [11:0] exp_sum;
    logic [4:0]  exp_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic c, input logic iv,
                     input logic [7:0] p, input logic o, input logic er,
                     input logic ev, input logic [11:0] es,
                     input logic [4:0] ec);
    vec_t v;
    v.rst = r; v.clr = c; v.iv = iv; v.prod = p; v.ordy = o;
    v.exp_rdy = er; v.exp_vld = ev; v.exp_sum = es; v.exp_cnt = ec;
    tbl.push_back(v);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic r, input logic c, input logic iv,
                       input logic [7:0] p, input logic o);
    @(negedge clk);
    rst = r; clear = c; in_valid = iv; prod_in = p; out_ready = o;
  endtask

  task automatic do_reset(input string tag);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    check({tag, " reset out_valid"}, {31'b0, vld4}, 32'd0);
    check({tag, " reset out_sum"},   {20'b0, sum4}, 32'd0);
    check({tag, " reset term_cnt"},  {27'b0, cnt4}, 32'd0);
    check({tag, " reset in_ready"},  {31'b0, rdy4}, 32'd1);
    check({tag, " reset in_ready n16"}, {31'b0, rdy16}, 32'd1);
    check({tag, " reset in_ready n1"},  {31'b0, rdy1},  32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; prod_in = 8'h00; out_ready = 1'b0;

    // Back-to-back full scale: 4 x 225 = 900 (0x384).
    for (int i = 1; i <= 3; i++) add(0, 0, 1, 8'hE1, 0, 1, 0, 12'h000, 5'(i));
    add(0, 0, 1, 8'hE1, 0, 1, 1, 12'h384, 0);
    // Backpressure: the offered 0x10 must not be taken while the result waits.
    for (int i = 0; i < 5; i++) add(0, 0, 1, 8'h10, 0, 0, 1, 12'h384, 0);
    add(0, 0, 1, 8'h10, 1, 0, 0, 12'h384, 0);
    add(0, 0, 0, 8'h00, 0, 1, 0, 12'h384, 0);
    // Clear mid-run: 7 and 9 are thrown away, and so is the 0x50 offered
    // with clear. Then 1+2+3+4 = 10.
    add(0, 0, 1, 8'd7,  0, 1, 0, 12'h384, 1);
    add(0, 0, 1, 8'd9,  0, 1, 0, 12'h384, 2);
    add(0, 1, 1, 8'h50, 0, 0, 0, 12'h384, 0);
    add(0, 0, 1, 8'd1,  0, 1, 0, 12'h384, 1);
    add(0, 0, 1, 8'd2,  0, 1, 0, 12'h384, 2);
    add(0, 0, 1, 8'd3,  0, 1, 0, 12'h384, 3);
    add(0, 0, 1, 8'd4,  0, 1, 1, 12'd10,  0);
    add(0, 0, 0, 8'h00, 1, 0, 0, 12'd10,  0);
    // Gaps: 3, idle, 5, idle, idle, 6, 1 -> 15. Then reset while in HOLD.
    add(0, 0, 1, 8'd3,  0, 1, 0, 12'd10, 1);
    add(0, 0, 0, 8'hAA, 0, 1, 0, 12'd10, 1);
    add(0, 0, 1, 8'd5,  0, 1, 0, 12'd10, 2);
    add(0, 0, 0, 8'hAA, 0, 1, 0, 12'd10, 2);
    add(0, 0, 0, 8'hAA, 0, 1, 0, 12'd10, 2);
    add(0, 0, 1, 8'd6,  0, 1, 0, 12'd10, 3);
    add(0, 0, 1, 8'd1,  0, 1, 1, 12'd15, 0);
    add(1, 0, 1, 8'd9,  1, 0, 0, 12'd0,  0);
    add(0, 0, 0, 8'h00, 0, 1, 0, 12'd0,  0);
    // Clear in HOLD wins over a simultaneous out_ready and discards the
    // result. out_sum keeps its old value.
    for (int i = 1; i <= 3; i++) add(0, 0, 1, 8'd1, 0, 1, 0, 12'd0, 5'(i));
    add(0, 0, 1, 8'd1,  0, 1, 1, 12'd4, 0);
    add(0, 1, 1, 8'd2,  1, 0, 0, 12'd4, 0);
    add(0, 0, 0, 8'h00, 0, 1, 0, 12'd4, 0);
    // Reset in the middle of a run.
    add(0, 0, 1, 8'd8,  0, 1, 0, 12'd4, 1);
    add(1, 0, 1, 8'd8,  0, 1, 0, 12'd0, 0);

    do_reset("n4");
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].clr, tbl[i].iv, tbl[i].prod, tbl[i].ordy);
      #1;
      check($sformatf("v%0d in_ready", i), {31'b0, rdy4}, {31'b0, tbl[i].exp_rdy});
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), {31'b0, vld4}, {31'b0, tbl[i].exp_vld});
      check($sformatf("v%0d fsm_state", i), {31'b0, st4},  {31'b0, tbl[i].exp_vld});
      check($sformatf("v%0d out_sum", i),   {20'b0, sum4}, {20'b0, tbl[i].exp_sum});
      check($sformatf("v%0d term_cnt", i),  {27'b0, cnt4}, {27'b0, tbl[i].exp_cnt});
    end

    // Maximum sum: 16 x 225 = 3600 (0xE10), with no wrap.
    do_reset("n16");
    exp_q.push_back(12'hE10);
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'hE1, 1'b0);
      @(posedge clk);
      #1;
      if (i == 15) begin
        check("n16 not done after 15", {31'b0, vld16}, 32'd0);
        check("n16 term_cnt after 15", {27'b0, cnt16}, 32'd15);
      end
    end
    check("n16 out_valid", {31'b0, vld16}, 32'd1);
    check("n16 out_sum",   {20'b0, sum16}, {20'b0, exp_q.pop_front()});
    check("n16 term_cnt",  {27'b0, cnt16}, 32'd0);
    check("n16 in_ready",  {31'b0, rdy16}, 32'd0);

    // A single-term run goes straight to HOLD with each product.
    do_reset("n1");
    exp_q.push_back(12'h05A);
    exp_q.push_back(12'h0C3);
    drive(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
    @(posedge clk); #1;
    check("n1 first out_valid", {31'b0, vld1}, 32'd1);
    check("n1 first out_sum",   {20'b0, sum1}, {20'b0, exp_q.pop_front()});
    check("n1 in_ready hold",   {31'b0, rdy1}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    @(posedge clk); #1;
    check("n1 released",       {31'b0, vld1}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 8'hC3, 1'b0);
    @(posedge clk); #1;
    check("n1 second out_sum",  {20'b0, sum1}, {20'b0, exp_q.pop_front()});
    check("n1 second out_valid", {31'b0, vld1}, 32'd1);
    check("n1 term_cnt",        {27'b0, cnt1}, 32'd0);
    check("n1 queue drained",   exp_q.size(), 32'd0);

    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The module SHALL have parameter N_TERMS, default 4, meaning the number of products summed per result; legal range is 1..16.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port prod_in, input, 8 bits: unsigned product from the 4x4 array multiplier.
REQ-005 The module SHALL have port in_valid, input, 1 bit: prod_in is valid this cycle.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block accepts prod_in this cycle.
REQ-007 The module SHALL have port clear, input, 1 bit: abort the current accumulation.
REQ-008 The module SHALL have port out_sum, output, 12 bits: the completed sum.
REQ-009 The module SHALL have port out_valid, output, 1 bit: out_sum holds a completed result.
REQ-010 The module SHALL have port out_ready, input, 1 bit: the consumer takes out_sum this cycle.
REQ-011 The module SHALL have port term_cnt, output, 5 bits: number of products accepted into the current accumulation.

Function
REQ-012 A product SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-013 The state machine SHALL have exactly two states: ACC (accumulating) and HOLD (result pending).
REQ-014 In state ACC, in_ready SHALL be 1 when clear=0 and 0 when clear=1; in state HOLD, in_ready SHALL be 0.
REQ-015 In ACC, each accepted product SHALL be added to a 12-bit accumulator with zero-extension, and term_cnt SHALL increment by 1.
REQ-016 The accumulator SHALL never wrap, because 16 x 225 = 3600 < 4096; no saturation logic is required.
REQ-017 On acceptance of the N_TERMS-th product, in the next cycle: out_sum = accumulator + that product, out_valid = 1, state = HOLD, accumulator = 0 and term_cnt = 0.
REQ-018 Result latency SHALL be exactly 1 cycle after the final accepted product.
REQ-019 In HOLD, out_sum and out_valid SHALL remain stable until a cycle with out_ready=1.
REQ-020 After the out_ready=1 cycle in HOLD, out_valid SHALL be 0 and state SHALL be ACC in the next cycle; there is no same-cycle bypass, so a new product is accepted no earlier than the cycle after the handshake.
REQ-021 out_sum SHALL keep its last value after out_valid falls.
REQ-022 Cycles with in_valid=0 SHALL leave the accumulator and term_cnt unchanged.
REQ-023 When clear=1 in ACC, the accumulator and term_cnt SHALL be 0 next cycle; clear takes priority over a simultaneous in_valid, and no product is accepted in that cycle.
REQ-024 When clear=1 in HOLD, the result SHALL be discarded: next cycle out_valid=0, state=ACC, accumulator=0, term_cnt=0; clear takes priority over a simultaneous out_ready.
REQ-025 With N_TERMS=1, every accepted product SHALL go directly to HOLD with out_sum = prod_in.

Reset
REQ-026 While rst=1 at a clock edge, the next state SHALL be: state=ACC, accumulator=0, term_cnt=0, out_sum=0, out_valid=0.
REQ-027 rst SHALL override clear, in_valid and out_ready, and SHALL take effect in any state, including mid-accumulation and HOLD; any pending result is lost.
REQ-028 After rst is released, in_ready SHALL be 1 in the first cycle.

Verification
REQ-029 Reset check: assert rst for 2 cycles, then release -> out_valid=0, out_sum=0x000, term_cnt=0, in_ready=1.
REQ-030 Back-to-back full scale: N_TERMS=4, four back-to-back products of 0xE1 -> one cycle after the 4th, out_valid=1, out_sum=900 (0x384), in_ready=0.
REQ-031 Backpressure: in HOLD, hold out_ready=0 for 5 cycles while in_valid=1 with prod_in=0x10 -> no product accepted and out_sum stable; then out_ready=1 for 1 cycle -> next cycle out_valid=0, in_ready=1, term_cnt=0.
REQ-032 Clear mid-run: N_TERMS=4, accept 7 and 9, then pulse clear together with in_valid (prod_in=0x50), then accept 1, 2, 3, 4 -> out_sum=10.
REQ-033 Gaps and reset in HOLD: N_TERMS=4, products 3, idle, 5, idle, idle, 6, 1 -> out_sum=15; then assert rst during HOLD -> out_valid=0 and out_sum=0 next cycle.
REQ-034 Maximum sum: N_TERMS=16, sixteen products of 0xE1 -> out_sum=3600 (0xE10), no wrap.
